// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared state type and default geometry for the deserializer
package deserializer_pkg;

  // COLLECT: filling sample registers; FULL: frame presented downstream
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  localparam int DEFAULT_BIT_WIDTH = 32;
  localparam int DEFAULT_N_SAMPLES = 8;

endpackage

// File: rtl/deserializer_control.sv
// rtl/deserializer_control.sv - frame FSM, write index and per-sample write enables
module deserializer_control
  import deserializer_pkg::*;
#(
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  input  logic                 send_rdy,
  output logic                 recv_rdy,
  output logic                 send_val,
  output logic [N_SAMPLES-1:0] wr_en,
  output logic                 cnt_clr
);

  localparam int            CW   = $clog2(N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // State and write index registers; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, next index, handshake outputs and write enables
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    wr_en     = '0;
    cnt_clr   = 1'b0;
    if (!reset) begin
      unique case (state)
        COLLECT: begin
          recv_rdy = 1'b1;
          if (recv_val) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
              wr_en[i] = (cnt == CW'(i));
            end
            if (cnt == LAST) begin
              cnt_clr   = 1'b1;
              state_nxt = FULL;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        FULL: begin
          send_val = 1'b1;
          // A sample may only enter while the held frame is leaving
          recv_rdy = send_rdy;
          if (send_rdy) begin
            state_nxt = COLLECT;
            if (recv_val) begin
              // First sample of the next frame lands in the same cycle
              wr_en[0] = 1'b1;
              cnt_nxt  = CW'(1);
            end else begin
              cnt_clr = 1'b1;
            end
          end
        end
      endcase
      if (cnt_clr) begin
        cnt_nxt = '0;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial samples in, one parallel frame of N_SAMPLES words out
module deserializer
  import deserializer_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES],
  output logic                 send_val,
  input  logic                 send_rdy
);

  logic [N_SAMPLES-1:0] wr_en;
  // Index-clear decision is kept visible for debug; the datapath needs only wr_en
  logic                 cnt_clr_unused;

  deserializer_control #(
    .N_SAMPLES (N_SAMPLES)
  ) u_control (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .wr_en    (wr_en),
    .cnt_clr  (cnt_clr_unused)
  );

  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_sample
    logic [BIT_WIDTH-1:0] sample_q;

    // Sample register i: cleared by reset, loaded when its enable fires
    always_ff @(posedge clk) begin
      if (reset) begin
        sample_q <= '0;
      end else if (wr_en[i]) begin
        sample_q <= recv_msg;
      end
    end

    assign send_msg[i] = sample_q;
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed scoreboard bench for deserializer (N=8 and N=2 instances)
module tb_deserializer;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int W2 = 16;
  localparam int N2 = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  recv_msg = '0;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [W-1:0]  send_msg [N];
  logic          send_val;
  logic          send_rdy = 1'b0;

  logic [W2-1:0] r2_msg = '0;
  logic          r2_val = 1'b0;
  logic          r2_rdy;
  logic [W2-1:0] s2_msg [N2];
  logic          s2_val;
  logic          s2_rdy = 1'b0;

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  logic           m_full = 1'b0;
  int             m_cnt  = 0;
  logic [N*W-1:0] m_regs = '0;
  logic [N*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val),
    .recv_rdy(recv_rdy), .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy)
  );

  deserializer #(.BIT_WIDTH(W2), .N_SAMPLES(N2)) dut2 (
    .clk(clk), .reset(reset), .recv_msg(r2_msg), .recv_val(r2_val),
    .recv_rdy(r2_rdy), .send_msg(s2_msg), .send_val(s2_val), .send_rdy(s2_rdy)
  );

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_msg();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = send_msg[i];
    return v;
  endfunction

  // Called just after a falling edge with inputs driven; checks, then advances one cycle
  task automatic tick(input string tag);
    logic exp_rdy, exp_val, rfire, sfire;
    logic [N*W-1:0] front;
    #2;
    exp_val = !reset && m_full;
    exp_rdy = !reset && (m_full ? send_rdy : 1'b1);
    chk({tag, "_recv_rdy"}, N*W'(recv_rdy), N*W'(exp_rdy));
    chk({tag, "_send_val"}, N*W'(send_val), N*W'(exp_val));
    if (!reset) chk({tag, "_send_msg"}, pack_msg(), m_regs);
    rfire = recv_val && exp_rdy;
    sfire = exp_val && send_rdy;
    if (sfire) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_underflow"}, 1, 0);
      end else begin
        front = exp_q.pop_front();
        chk({tag, "_frame"}, pack_msg(), front);
      end
    end
    if (reset) begin
      m_full = 1'b0;
      m_cnt  = 0;
      m_regs = '0;
      exp_q.delete();
    end else begin
      if (sfire) m_full = 1'b0;
      if (rfire) begin
        m_regs[m_cnt*W +: W] = recv_msg;
        if (m_cnt == N - 1) begin
          m_cnt  = 0;
          m_full = 1'b1;
          exp_q.push_back(m_regs);
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [W-1:0] m, input logic s, input string tag);
    recv_val = v;
    recv_msg = m;
    send_rdy = s;
    tick(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    // Reset with stimulus active: handshakes must stay low
    step(1, 32'h11, 1, "rst");
    step(1, 32'h11, 1, "rst");
    reset = 1'b0;
    step(0, 0, 1, "idle");

    // Basic frame 1..8
    for (int i = 1; i <= 8; i++) step(1, W'(i), 1, "basic");
    step(0, 0, 1, "basic_out");
    step(0, 0, 1, "basic_after");

    // Backpressure with A0..A7
    for (int i = 0; i < 8; i++) step(1, W'(32'hA0 + i), 0, "bp_fill");
    for (int i = 0; i < 5; i++) step(1, 32'hEE, 0, "bp_hold");
    step(0, 0, 1, "bp_send");
    step(0, 0, 0, "bp_after");
    chk("bp_single_send", N*W'(exp_q.size()), '0);

    // Back-to-back 0x10..0x1F
    for (int i = 0; i < 16; i++) step(1, W'(32'h10 + i), 1, "b2b");
    step(0, 0, 1, "b2b_out");
    step(0, 0, 1, "b2b_after");

    // Gapped input: values 0..7 on even cycles, junk on gaps
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1, W'(i / 2), 1, "gap");
      else            step(0, 32'hFF, 1, "gap");
    end
    step(0, 0, 1, "gap_after");

    // Reset mid-frame, then a clean frame 0x50..0x57
    for (int i = 0; i < 3; i++) step(1, W'(32'h30 + i), 1, "mid");
    reset = 1'b1;
    step(1, 32'h77, 1, "mid_rst");
    step(1, 32'h77, 1, "mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1, W'(32'h50 + i), 1, "post_rst");
    step(0, 0, 1, "post_rst_out");

    // Reset while FULL with send and recv both requested: reset wins
    for (int i = 0; i < 8; i++) step(1, W'(32'h60 + i), 0, "prio_fill");
    step(0, 0, 0, "prio_full");
    reset = 1'b1;
    step(1, 32'h99, 1, "prio_rst");
    reset = 1'b0;
    step(0, 0, 1, "prio_after");
    step(1, 32'hC0, 1, "prio_restart");
    chk("prio_cnt_restart", N*W'(m_cnt), N*W'(1));

    // N_SAMPLES = 2 instance
    r2_val = 1'b1; r2_msg = 16'hDEAD; s2_rdy = 1'b0;
    #2;
    chk("n2_rdy0", N*W'(r2_rdy), N*W'(1));
    chk("n2_val0", N*W'(s2_val), '0);
    @(negedge clk);
    r2_msg = 16'hBEEF;
    #2;
    chk("n2_rdy1", N*W'(r2_rdy), N*W'(1));
    @(negedge clk);
    r2_val = 1'b0;
    #2;
    chk("n2_full_val", N*W'(s2_val), N*W'(1));
    chk("n2_full_rdy", N*W'(r2_rdy), '0);
    chk("n2_msg0", N*W'(s2_msg[0]), N*W'(16'hDEAD));
    chk("n2_msg1", N*W'(s2_msg[1]), N*W'(16'hBEEF));
    @(negedge clk);
    s2_rdy = 1'b1; r2_val = 1'b1; r2_msg = 16'h1234;
    #2;
    chk("n2_pass_rdy", N*W'(r2_rdy), N*W'(1));
    @(negedge clk);
    s2_rdy = 1'b0; r2_msg = 16'h5678;
    #2;
    chk("n2_wrap_val", N*W'(s2_val), '0);
    chk("n2_wrap_rdy", N*W'(r2_rdy), N*W'(1));
    @(negedge clk);
    r2_val = 1'b0;
    #2;
    chk("n2_f2_val", N*W'(s2_val), N*W'(1));
    chk("n2_f2_msg0", N*W'(s2_msg[0]), N*W'(16'h1234));
    chk("n2_f2_msg1", N*W'(s2_msg[1]), N*W'(16'h5678));
    @(negedge clk);

    chk("queue_drained", N*W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
